sw_fpga_wrapper: RTL and testbench

- Self-contained FPGA top for Smith-Waterman local alignment with affine gap penalties.
- Holds a built-in target sequence T and query sequence S as parameter constants.
- i_set_t loads T into a linear systolic array of processing elements (PEs). i_start_cal streams S through the array using the run-time scoring parameters, then reports the maximum local alignment score.
- Sits directly under the board top-level; pins/switches drive the scoring nibbles and the control strobes.

---
 rtl/sw_pkg.sv | 31 +++
 rtl/sw_pe.sv | 129 ++++++++++++
 rtl/sw_fpga_wrapper.sv | 204 ++++++++++++++++++++
 tb/tb_sw_fpga_wrapper.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_pkg
// Description : Shared types and constants for the Smith-Waterman FPGA top:
//               score width default, nucleotide encoding, FSM state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

    // Default width of H/E/F scores and of the reported result
    localparam int V_E_F_BIT_DEF = 10;

    // 2-bit nucleotide encoding
    typedef logic [1:0] nt_t;
    localparam nt_t NT_A = 2'd0;
    localparam nt_t NT_C = 2'd1;
    localparam nt_t NT_G = 2'd2;
    localparam nt_t NT_T = 2'd3;

    // Score at the default width
    typedef logic [V_E_F_BIT_DEF-1:0] score_t;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_CALC = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage : sw_pkg
`default_nettype wire

// File: rtl/sw_pe.sv
`default_nettype none
// ============================================================================
// Module      : sw_pe
// Description : One systolic processing element. Holds a single target char
//               and computes one matrix column: H/E/F per query char plus the
//               running maximum of H seen by this column.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_pe
    import sw_pkg::*;
#(
    parameter int V_E_F_Bit = V_E_F_BIT_DEF
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_load,
    input  wire nt_t                  i_t,
    output logic [1:0]                o_t,
    input  wire logic                 i_clr,
    input  wire logic                 i_v,
    input  wire nt_t                  i_s,
    input  wire logic [V_E_F_Bit-1:0] i_h,
    input  wire logic [V_E_F_Bit-1:0] i_e,
    input  wire logic [3:0]           i_match,
    input  wire logic [3:0]           i_mismatch,
    input  wire logic [3:0]           i_alpha,
    input  wire logic [3:0]           i_beta,
    output logic                      o_v,
    output logic [1:0]                o_s,
    output logic [V_E_F_Bit-1:0]      o_h,
    output logic [V_E_F_Bit-1:0]      o_e,
    output logic [V_E_F_Bit-1:0]      o_max
);

    // One sign bit plus one carry bit so score+match never wraps before clamping
    localparam int W = V_E_F_Bit + 2;
    localparam logic signed [W-1:0] C_SAT = $signed({2'b00, {V_E_F_Bit{1'b1}}});

    function automatic logic signed [W-1:0] ext(input logic [V_E_F_Bit-1:0] v);
        ext = $signed({2'b00, v});
    endfunction

    function automatic logic signed [W-1:0] ext4(input logic [3:0] v);
        ext4 = $signed({{(W-4){1'b0}}, v});
    endfunction

    function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        smax = (a > b) ? a : b;
    endfunction

    // Floor at zero (local alignment) and saturate at the top of the range
    function automatic logic [V_E_F_Bit-1:0] clamp(input logic signed [W-1:0] x);
        if (x < 0)          clamp = '0;
        else if (x > C_SAT) clamp = '1;
        else                clamp = x[V_E_F_Bit-1:0];
    endfunction

    nt_t                  r_t;
    logic                 r_v;
    nt_t                  r_s;
    logic [V_E_F_Bit-1:0] r_h;       // H of the previous query char (this column)
    logic [V_E_F_Bit-1:0] r_e;
    logic [V_E_F_Bit-1:0] r_f;       // F of the previous query char (this column)
    logic [V_E_F_Bit-1:0] r_h_diag;  // left-neighbour H one query char ago
    logic [V_E_F_Bit-1:0] r_max;

    logic [V_E_F_Bit-1:0]  w_e;
    logic [V_E_F_Bit-1:0]  w_f;
    logic [V_E_F_Bit-1:0]  w_h;
    logic signed [W-1:0]   w_diag;

    // Cell recurrences: gap from the left neighbour (E), gap from this column's
    // previous cell (F), and the diagonal substitution score
    always_comb begin
        w_e    = clamp(smax(ext(i_h) - ext4(i_alpha), ext(i_e) - ext4(i_beta)));
        w_f    = clamp(smax(ext(r_h) - ext4(i_alpha), ext(r_f) - ext4(i_beta)));
        w_diag = ext(r_h_diag) + ((i_s == r_t) ? ext4(i_match) : -ext4(i_mismatch));
        w_h    = clamp(smax(smax(ext(w_e), ext(w_f)), w_diag));
    end

    // Target char shift register plus per-column score state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t      <= NT_A;
            r_v      <= 1'b0;
            r_s      <= NT_A;
            r_h      <= '0;
            r_e      <= '0;
            r_f      <= '0;
            r_h_diag <= '0;
            r_max    <= '0;
        end else begin
            if (i_load) begin
                r_t <= i_t;
            end
            if (i_clr) begin
                r_v      <= 1'b0;
                r_s      <= NT_A;
                r_h      <= '0;
                r_e      <= '0;
                r_f      <= '0;
                r_h_diag <= '0;
                r_max    <= '0;
            end else begin
                r_v <= i_v;
                r_s <= i_s;
                if (i_v) begin
                    r_h      <= w_h;
                    r_e      <= w_e;
                    r_f      <= w_f;
                    r_h_diag <= i_h;
                    if (w_h > r_max) begin
                        r_max <= w_h;
                    end
                end
            end
        end
    end

    assign o_t   = r_t;
    assign o_v   = r_v;
    assign o_s   = r_s;
    assign o_h   = r_h;
    assign o_e   = r_e;
    assign o_max = r_max;

endmodule : sw_pe
`default_nettype wire

// File: rtl/sw_fpga_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : sw_fpga_wrapper
// Description : FPGA top for Smith-Waterman local alignment with affine gaps.
//               Loads a built-in target into a linear PE chain, streams the
//               built-in query through it and reports the maximum H score.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_fpga_wrapper
    import sw_pkg::*;
#(
    parameter int                 T_LEN     = 8,
    parameter int                 S_LEN     = 8,
    parameter logic [2*T_LEN-1:0] T_SEQ     = 16'hE4E4,   // "ACGTACGT"
    parameter logic [2*S_LEN-1:0] S_SEQ     = 16'hE4E4,   // "ACGTACGT"
    parameter int                 V_E_F_Bit = V_E_F_BIT_DEF
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_set_t,
    input  wire logic                 i_start_cal,
    input  wire logic [3:0]           i_match,
    input  wire logic [3:0]           i_mismatch,
    input  wire logic [3:0]           i_minusAlpha,
    input  wire logic [3:0]           i_minusBeta,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic [V_E_F_Bit-1:0]      o_result
);

    localparam int CW = $clog2(S_LEN + T_LEN + 1);
    localparam logic [CW-1:0] C_LOAD_LAST = CW'(T_LEN - 1);
    localparam logic [CW-1:0] C_CALC_LAST = CW'(S_LEN + T_LEN - 1);

    state_t               r_state,  w_state_nxt;
    logic [CW-1:0]        r_cnt,    w_cnt_nxt;
    logic                 r_loaded, w_loaded_nxt;
    logic [V_E_F_Bit-1:0] r_result, w_result_nxt;
    logic [3:0]           r_match, r_mismatch, r_alpha, r_beta;

    logic                 w_pe_load;
    logic                 w_pe_clr;
    logic                 w_latch_scores;
    logic                 w_feed_v;
    nt_t                  w_feed_s;
    nt_t                  w_load_t;
    int                   w_s_idx;
    int                   w_t_idx;
    logic [V_E_F_Bit-1:0] w_gmax;

    logic                 w_in_v  [T_LEN];
    nt_t                  w_in_s  [T_LEN];
    logic [V_E_F_Bit-1:0] w_in_h  [T_LEN];
    logic [V_E_F_Bit-1:0] w_in_e  [T_LEN];
    nt_t                  w_in_t  [T_LEN];
    logic                 w_out_v [T_LEN];
    logic [1:0]           w_out_s [T_LEN];
    logic [V_E_F_Bit-1:0] w_out_h [T_LEN];
    logic [V_E_F_Bit-1:0] w_out_e [T_LEN];
    logic [1:0]           w_out_t [T_LEN];
    logic [V_E_F_Bit-1:0] w_max   [T_LEN];

    // Controller: next state, counter, loaded flag and result capture
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_loaded_nxt   = r_loaded;
        w_result_nxt   = r_result;
        w_pe_load      = 1'b0;
        w_pe_clr       = 1'b0;
        w_latch_scores = 1'b0;
        w_feed_v       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_set_t) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end else if (i_start_cal && r_loaded) begin
                    w_state_nxt    = ST_CALC;
                    w_cnt_nxt      = '0;
                    w_pe_clr       = 1'b1;
                    w_latch_scores = 1'b1;
                end
            end
            ST_LOAD: begin
                w_pe_load = 1'b1;
                if (r_cnt == C_LOAD_LAST) begin
                    w_state_nxt  = ST_IDLE;
                    w_loaded_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_CALC: begin
                w_feed_v = (r_cnt < CW'(S_LEN));
                // The last cell settled on the previous edge, so the maxima are final
                if (r_cnt == C_CALC_LAST) begin
                    w_state_nxt  = ST_DONE;
                    w_result_nxt = w_gmax;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Controller registers and the scoring parameters held for one run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_loaded   <= 1'b0;
            r_result   <= '0;
            r_match    <= '0;
            r_mismatch <= '0;
            r_alpha    <= '0;
            r_beta     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_loaded <= w_loaded_nxt;
            r_result <= w_result_nxt;
            if (w_latch_scores) begin
                r_match    <= i_match;
                r_mismatch <= i_mismatch;
                r_alpha    <= i_minusAlpha;
                r_beta     <= i_minusBeta;
            end
        end
    end

    // Head-of-chain chars: query char for this cycle, and target fed last
    // char first so that PE k ends up holding T[k]
    always_comb begin
        w_s_idx  = w_feed_v ? int'(r_cnt) : 0;
        w_t_idx  = (r_state == ST_LOAD) ? (T_LEN - 1 - int'(r_cnt)) : 0;
        w_feed_s = S_SEQ[2*w_s_idx +: 2];
        w_load_t = T_SEQ[2*w_t_idx +: 2];
    end

    for (genvar g = 0; g < T_LEN; g++) begin : g_pe
        if (g == 0) begin : g_head
            assign w_in_v[g] = w_feed_v;
            assign w_in_s[g] = w_feed_s;
            assign w_in_h[g] = '0;
            assign w_in_e[g] = '0;
            assign w_in_t[g] = w_load_t;
        end else begin : g_link
            assign w_in_v[g] = w_out_v[g-1];
            assign w_in_s[g] = w_out_s[g-1];
            assign w_in_h[g] = w_out_h[g-1];
            assign w_in_e[g] = w_out_e[g-1];
            assign w_in_t[g] = w_out_t[g-1];
        end

        sw_pe #(
            .V_E_F_Bit (V_E_F_Bit)
        ) u_pe (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_pe_load),
            .i_t        (w_in_t[g]),
            .o_t        (w_out_t[g]),
            .i_clr      (w_pe_clr),
            .i_v        (w_in_v[g]),
            .i_s        (w_in_s[g]),
            .i_h        (w_in_h[g]),
            .i_e        (w_in_e[g]),
            .i_match    (r_match),
            .i_mismatch (r_mismatch),
            .i_alpha    (r_alpha),
            .i_beta     (r_beta),
            .o_v        (w_out_v[g]),
            .o_s        (w_out_s[g]),
            .o_h        (w_out_h[g]),
            .o_e        (w_out_e[g]),
            .o_max      (w_max[g])
        );
    end

    // Reduce the per-column maxima to the global maximum
    always_comb begin
        w_gmax = '0;
        for (int k = 0; k < T_LEN; k++) begin
            if (w_max[k] > w_gmax) begin
                w_gmax = w_max[k];
            end
        end
    end

    assign o_busy   = (r_state != ST_IDLE);
    assign o_valid  = (r_state == ST_DONE);
    assign o_result = r_result;

endmodule : sw_fpga_wrapper
`default_nettype wire

// File: tb/tb_sw_fpga_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_fpga_wrapper
// Description : Self-checking bench. Four wrappers with different built-in
//               sequences share the controls; a dynamic-programming reference
//               fills per-instance expected queues when a run starts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_fpga_wrapper;

    localparam int NDUT = 4;
    // Packed sequences, char k in bits [2k+1:2k]; A=0 C=1 G=2 T=3
    localparam logic [15:0] C_T0 = {2'd3,2'd2,2'd1,2'd0,2'd3,2'd2,2'd1,2'd0}; // ACGTACGT
    localparam logic [15:0] C_S1 = {2'd3,2'd2,2'd1,2'd3,2'd3,2'd2,2'd1,2'd0}; // ACGTTCGT
    localparam logic [15:0] C_S2 = {2'd2,2'd1,2'd0,2'd3,2'd3,2'd2,2'd1,2'd0}; // ACGTTACG
    localparam logic [15:0] C_T3 = 16'h0000;                                   // AAAAAAAA
    localparam logic [15:0] C_S3 = 16'h5555;                                   // CCCCCCCC

    logic       clk = 1'b0;
    logic       rst;
    logic       set_t, start_cal;
    logic [3:0] match, mismatch, alpha, beta;
    logic       busy   [NDUT];
    logic       valid  [NDUT];
    logic [9:0] result [NDUT];

    logic [15:0] tseq [NDUT];
    logic [15:0] sseq [NDUT];

    int n_err = 0;
    int n_chk = 0;
    int n_valid [NDUT];
    int exp_q [NDUT][$];

    always #5 clk = ~clk;

    sw_fpga_wrapper #(.T_LEN(8), .S_LEN(8), .T_SEQ(C_T0), .S_SEQ(C_T0), .V_E_F_Bit(10)) u_dut0 (
        .clk(clk), .rst(rst), .i_set_t(set_t), .i_start_cal(start_cal),
        .i_match(match), .i_mismatch(mismatch), .i_minusAlpha(alpha), .i_minusBeta(beta),
        .o_busy(busy[0]), .o_valid(valid[0]), .o_result(result[0]));
    sw_fpga_wrapper #(.T_LEN(8), .S_LEN(8), .T_SEQ(C_T0), .S_SEQ(C_S1), .V_E_F_Bit(10)) u_dut1 (
        .clk(clk), .rst(rst), .i_set_t(set_t), .i_start_cal(start_cal),
        .i_match(match), .i_mismatch(mismatch), .i_minusAlpha(alpha), .i_minusBeta(beta),
        .o_busy(busy[1]), .o_valid(valid[1]), .o_result(result[1]));
    sw_fpga_wrapper #(.T_LEN(8), .S_LEN(8), .T_SEQ(C_T0), .S_SEQ(C_S2), .V_E_F_Bit(10)) u_dut2 (
        .clk(clk), .rst(rst), .i_set_t(set_t), .i_start_cal(start_cal),
        .i_match(match), .i_mismatch(mismatch), .i_minusAlpha(alpha), .i_minusBeta(beta),
        .o_busy(busy[2]), .o_valid(valid[2]), .o_result(result[2]));
    sw_fpga_wrapper #(.T_LEN(8), .S_LEN(8), .T_SEQ(C_T3), .S_SEQ(C_S3), .V_E_F_Bit(10)) u_dut3 (
        .clk(clk), .rst(rst), .i_set_t(set_t), .i_start_cal(start_cal),
        .i_match(match), .i_mismatch(mismatch), .i_minusAlpha(alpha), .i_minusBeta(beta),
        .o_busy(busy[3]), .o_valid(valid[3]), .o_result(result[3]));

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int clampi(input int x);
        if (x < 0)    return 0;
        if (x > 1023) return 1023;
        return x;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Full-matrix Smith-Waterman reference with affine gaps
    function automatic int sw_ref(input logic [15:0] t, input logic [15:0] s,
                                  input int m, input int mm, input int a, input int b);
        int h [0:8][0:8];
        int e [0:8][0:8];
        int f [0:8][0:8];
        int best;
        int d;
        best = 0;
        for (int i = 0; i <= 8; i++)
            for (int j = 0; j <= 8; j++) begin
                h[i][j] = 0; e[i][j] = 0; f[i][j] = 0;
            end
        for (int i = 1; i <= 8; i++)
            for (int j = 1; j <= 8; j++) begin
                e[i][j] = clampi(max2(h[i][j-1] - a, e[i][j-1] - b));
                f[i][j] = clampi(max2(h[i-1][j] - a, f[i-1][j] - b));
                d = h[i-1][j-1] + ((s[2*(i-1) +: 2] == t[2*(j-1) +: 2]) ? m : -mm);
                h[i][j] = clampi(max2(max2(e[i][j], f[i][j]), d));
                best = max2(best, h[i][j]);
            end
        return best;
    endfunction

    // Scoreboard: every valid pulse pops one expected result
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (valid[k] === 1'b1) begin
                n_valid[k]++;
                if (exp_q[k].size() == 0)
                    chk($sformatf("unexpected_valid_d%0d", k), 1, 0);
                else
                    chk($sformatf("result_d%0d", k), int'(result[k]), exp_q[k].pop_front());
            end
        end
    end

    task automatic pulse_set_t();
        @(negedge clk); set_t = 1'b1;
        @(negedge clk); set_t = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start_cal = 1'b1;
        @(negedge clk); start_cal = 1'b0;
    endtask

    task automatic do_load();
        int nb;
        nb = 0;
        pulse_set_t();
        for (int c = 0; c < 12; c++) begin
            #1;
            if (busy[0]) nb++;
            @(negedge clk);
        end
        chk("load_busy_cycles", nb, 8);
    endtask

    task automatic run_calc(input int m, input int mm, input int a, input int b,
                            input bit disturb);
        int v0;
        match = 4'(m); mismatch = 4'(mm); alpha = 4'(a); beta = 4'(b);
        for (int k = 0; k < NDUT; k++)
            exp_q[k].push_back(sw_ref(tseq[k], sseq[k], m, mm, a, b));
        v0 = n_valid[0];
        pulse_start();
        if (disturb) begin
            repeat (4) @(negedge clk);
            match = 4'd15; mismatch = 4'd0; alpha = 4'd0; beta = 4'd0;
            pulse_start();
        end
        for (int c = 0; c < 100 && n_valid[0] == v0; c++) begin
            @(negedge clk); #1;
        end
        chk("valid_seen", n_valid[0] - v0, 1);
        @(negedge clk); #1;
        chk("busy_after_done", int'(busy[0]), 0);
        chk("valid_one_cycle", int'(valid[0]), 0);
        if (disturb) begin
            repeat (20) @(negedge clk);
            chk("single_valid_with_restart", n_valid[0] - v0, 1);
        end
    endtask

    initial begin
        int nb;
        int v0;
        tseq[0] = C_T0; sseq[0] = C_T0;
        tseq[1] = C_T0; sseq[1] = C_S1;
        tseq[2] = C_T0; sseq[2] = C_S2;
        tseq[3] = C_T3; sseq[3] = C_S3;
        for (int k = 0; k < NDUT; k++) n_valid[k] = 0;
        rst = 1'b1; set_t = 1'b0; start_cal = 1'b0;
        match = 4'd2; mismatch = 4'd1; alpha = 4'd3; beta = 4'd1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_valid", int'(valid[0]), 0);
        chk("reset_result", int'(result[0]), 0);
        rst = 1'b0;

        // Start before any target load must be ignored
        pulse_start();
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            #1; if (busy[0]) nb++;
            @(negedge clk);
        end
        chk("start_unloaded_busy", nb, 0);
        chk("start_unloaded_valid", n_valid[0], 0);

        do_load();
        run_calc(2, 1, 3, 1, 1'b0);
        run_calc(2, 4, 15, 15, 1'b0);
        run_calc(2, 15, 15, 15, 1'b0);
        run_calc(2, 4, 3, 1, 1'b0);
        run_calc(2, 4, 15, 1, 1'b0);
        run_calc(0, 1, 3, 1, 1'b0);
        run_calc(3, 2, 4, 2, 1'b1);
        for (int r = 0; r < 3; r++)
            run_calc(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);

        // Reset in the middle of a calculation
        match = 4'd2; mismatch = 4'd1; alpha = 4'd3; beta = 4'd1;
        pulse_start();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("midrst_busy", int'(busy[0]), 0);
        chk("midrst_valid", int'(valid[0]), 0);
        chk("midrst_result", int'(result[0]), 0);
        rst = 1'b0;

        // Loaded flag is gone: start without a reload does nothing
        v0 = n_valid[0];
        pulse_start();
        nb = 0;
        for (int c = 0; c < 25; c++) begin
            #1; if (busy[0]) nb++;
            @(negedge clk);
        end
        chk("post_rst_start_busy", nb, 0);
        chk("post_rst_start_valid", n_valid[0] - v0, 0);

        do_load();
        run_calc(2, 1, 3, 1, 1'b0);

        repeat (5) @(negedge clk);
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("queue_empty_d%0d", k), exp_q[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_sw_fpga_wrapper
`default_nettype wire
